register_file_8x16: RTL and testbench
=====================================

# register_file_8x16

General-purpose register file for the 16-bit datapath: eight 16-bit registers, two independent asynchronous read ports and one synchronous write port. It sits between the instruction decoder (register addresses) and the ALU/writeback path (operands and results). All registers clear on an asynchronous active-low reset.

## Interface

Parameters:
- DATA_WIDTH, 16, width of each register and of all data ports
- ADDR_WIDTH, 3, register address width; depth is 2**ADDR_WIDTH (8 registers)

Ports:
- clk  input  1  single clock; all writes occur on its rising edge
- rst_n  input  1  asynchronous, active-low reset; clears all registers
- wr_en  input  1  write enable, active high, sampled on rising clk
- write_reg  input  ADDR_WIDTH  destination register index
- write_data  input  DATA_WIDTH  data to write
- read_reg1  input  ADDR_WIDTH  read port 1 register index
- read_reg2  input  ADDR_WIDTH  read port 2 register index
- read_data1  output  DATA_WIDTH  contents of register read_reg1
- read_data2  output  DATA_WIDTH  contents of register read_reg2

## Operation

- Storage: 2**ADDR_WIDTH registers, indices 0..7. All are ordinary storage, including register 0, which is writable and has no hardwired value.
- Write: at a rising clk edge with rst_n high and wr_en = 1, register[write_reg] <= write_data. With wr_en = 0, no register changes.
- Read: read_data1 = register[read_reg1] and read_data2 = register[read_reg2]. Both are purely combinational with no clock involvement.
  - Both ports may address the same register, each returning the same value.
  - Either port may address the register being written.
- No write-to-read bypass: during the cycle a write is pending, the read ports return the old contents. The new value appears only after the capturing edge.
- Reset: rst_n = 0 immediately forces every register to 0, without waiting for a clock. Both read outputs therefore read 0 for any address. Writes are blocked while rst_n = 0.
- Unknown or X addresses carry no required behaviour. All in-range addresses are full-decoded, with no aliasing.

## Timing

- Write latency: 1 clk edge. Data is visible on a read port addressing that register after the edge, within combinational delay.
- Read latency: 0 cycles. Outputs follow read address changes and register updates combinationally.
- Reset assertion is asynchronous. Reset deassertion takes effect at the first rising edge with rst_n high; a write with wr_en = 1 at that edge is performed.
- Reset asserted at the same time as a clock edge with wr_en = 1: reset wins and the register stays 0.
- Back-to-back writes to the same or different registers on consecutive edges are each committed. The last write to a given register wins.
- Outputs after reset: read_data1 = read_data2 = 16'h0000.

## Test plan

- Reset: assert rst_n = 0 mid-cycle with no clock edge. Sweep read_reg1/read_reg2 over 0..7; every read must be 16'h0000, immediately.
- Single write/read: with wr_en = 1, write_reg = 3, write_data = 16'hF000, apply one rising edge. Then set wr_en = 0, read_reg1 = 3, read_reg2 = 2. Required: read_data1 = 16'hF000, read_data2 = 16'h0000.
- Second write, no bypass: with read_reg2 = 2, set wr_en = 1, write_reg = 2, write_data = 16'h0F00.
  - Before the edge, read_data2 = 16'h0000.
  - After the edge, read_data2 = 16'h0F00, and read_data1 is still 16'hF000.
- Write-enable gating: set wr_en = 0, write_reg = 5, write_data = 16'hAAAA, and clock several edges. Register 5 must still read 16'h0000.
- Full sweep: write 16'h1111 * (i+1) to each register i = 0..7 on consecutive edges. Read all eight back through both ports, including both ports on the same address; every value must match. Then assert rst_n = 0 and confirm all eight read 16'h0000.
- Reset vs write: assert rst_n = 0 coincident with a rising edge where wr_en = 1, write_reg = 4, write_data = 16'h1234. Register 4 must read 16'h0000.

Source files
------------

// File: rtl/register_file_8x16.sv
// Register file for the 16-bit datapath: 2**ADDR_WIDTH registers,
// two combinational read ports, one synchronous write port, async clear.
module register_file_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      wr_sel;

  // One-hot decode of the write address; register 0 is ordinary storage.
  always_comb begin
    wr_sel = '0;
    if (wr_en) begin
      wr_sel[write_reg] = 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[g] <= '0;
      end else if (wr_sel[g]) begin
        regs[g] <= write_data;
      end
    end
  end

  // Reads see stored contents only, so a pending write is not forwarded.
  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];

endmodule

// File: tb/tb_register_file_8x16.sv
// Bench for register_file_8x16: table of write/read vectors checked before
// each capturing edge, plus hand sequences for sweep and reset corners.
module tb_register_file_8x16;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [15:0] read_data1;
  logic [15:0] read_data2;

  int vectors_applied = 0;
  int miscompares     = 0;
  logic [15:0] exp_q[$];

  register_file_8x16 #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] e1;  // read_data1 before the edge
    logic [15:0] e2;  // read_data2 before the edge
  } vec_t;

  vec_t vecs[13];

  // scoreboard
  task automatic push_exp(input logic [15:0] e1, input logic [15:0] e2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  task automatic check_one(input string name, input logic [15:0] act);
    logic [15:0] e;
    vectors_applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got %h, required an expected entry (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h, required %h", name, act, e);
      end
    end
  endtask

  task automatic check_reads(input string name);
    #1;
    check_one({name, "_rd1"}, read_data1);
    check_one({name, "_rd2"}, read_data2);
  endtask

  // driver tasks
  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2);
    wr_en      = we;
    write_reg  = wa;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  task automatic set_reads(input logic [2:0] r1, input logic [2:0] r2);
    read_reg1 = r1;
    read_reg2 = r2;
  endtask

  initial begin
    // write 3, reads before the edge see old contents
    vecs[0]  = '{1'b1, 3'd3, 16'hF000, 3'd3, 3'd2, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'hF000, 16'h0000};
    vecs[2]  = '{1'b1, 3'd2, 16'h0F00, 3'd3, 3'd2, 16'hF000, 16'h0000};
    vecs[3]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'hF000, 16'h0F00};
    // wr_en low must block the write
    vecs[4]  = '{1'b0, 3'd5, 16'hAAAA, 3'd5, 3'd5, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 3'd5, 16'hAAAA, 3'd5, 3'd5, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 3'd5, 16'hAAAA, 3'd5, 3'd5, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 3'd5, 16'hAAAA, 3'd5, 3'd3, 16'h0000, 16'hF000};
    // back-to-back writes to the same register, last wins
    vecs[8]  = '{1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd7, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 3'd7, 16'hCAFE, 3'd7, 3'd2, 16'hBEEF, 16'h0F00};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 16'hCAFE, 16'h0000};
    // register 0 is writable
    vecs[11] = '{1'b1, 3'd0, 16'h1234, 3'd0, 3'd7, 16'h0000, 16'hCAFE};
    vecs[12] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h1234, 16'hCAFE};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    #2;
    for (int i = 0; i < 8; i++) begin
      set_reads(3'(i), 3'(7 - i));
      push_exp(16'h0000, 16'h0000);
      check_reads($sformatf("init_reset_r%0d", i));
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      push_exp(vecs[i].e1, vecs[i].e2);
      check_reads($sformatf("vec%0d", i));
    end

    // full sweep of consecutive writes
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 3'd0, 3'd0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_reads(3'(i), 3'(7 - i));
      push_exp(16'(16'h1111 * (i + 1)), 16'(16'h1111 * (8 - i)));
      check_reads($sformatf("sweep_r%0d", i));
      set_reads(3'(i), 3'(i));
      push_exp(16'(16'h1111 * (i + 1)), 16'(16'h1111 * (i + 1)));
      check_reads($sformatf("sweep_same%0d", i));
    end

    // mid-cycle reset clears immediately, no clock edge needed
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_reads(3'(i), 3'(7 - i));
      push_exp(16'h0000, 16'h0000);
      check_reads($sformatf("async_reset_r%0d", i));
    end

    // writes blocked while reset held
    @(negedge clk);
    drive(1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd1);
    @(negedge clk);
    push_exp(16'h0000, 16'h0000);
    check_reads("write_in_reset");

    // write at the first edge after release is performed
    drive(1'b1, 3'd6, 16'h6666, 3'd6, 3'd4);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'd4, 16'h5555, 3'd6, 3'd4);
    push_exp(16'h6666, 16'h0000);
    check_reads("release_write");
    @(negedge clk);
    push_exp(16'h6666, 16'h5555);
    check_reads("reg4_preload");

    // reset coincident with a write edge: reset wins
    drive(1'b1, 3'd4, 16'h1234, 3'd4, 3'd6);
    @(posedge clk);
    rst_n = 1'b0;
    push_exp(16'h0000, 16'h0000);
    check_reads("reset_vs_write");
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(16'h0000, 16'h0000);
    check_reads("reset_vs_write_after");

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
